// File: rtl/boot_loader_pkg.sv
// Shared types for the program loader: memory port flags, loader states and
// the bundle of registered loader outputs.
package boot_loader_pkg;

    typedef logic [7:0] DEFAULT_TYPE;

    typedef enum logic [1:0] {
        MEMORY_READ  = 2'd0,
        MEMORY_WRITE = 2'd1,
        MEMORY_STAY  = 2'd2
    } MEMORY_FLAG_TYPE;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        FILL    = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4,
        FAULT   = 3'd5
    } LOADER_STATE_TYPE;

    localparam DEFAULT_TYPE HLT_FILL_DEFAULT = 8'hF0;

    // Everything the loader registers; the top holds exactly one of these.
    typedef struct packed {
        LOADER_STATE_TYPE state;
        logic [8:0]       ptr;
        logic [8:0]       count;
        logic             error;
        DEFAULT_TYPE      addr;
        DEFAULT_TYPE      data;
        MEMORY_FLAG_TYPE  rw;
        logic             owner;
        logic             cpu_reset;
        logic             in_ready;
    } LOADER_REGS_TYPE;

    localparam LOADER_REGS_TYPE LOADER_RESET = '{
        state:     IDLE,
        ptr:       9'd0,
        count:     9'd0,
        error:     1'b0,
        addr:      8'h00,
        data:      8'h00,
        rw:        MEMORY_STAY,
        owner:     1'b1,
        cpu_reset: 1'b1,
        in_ready:  1'b0
    };

endpackage

// File: rtl/boot_loader_next_state.sv
// Combinational next-state and next-output decode for the program loader.
// Handshake: a byte transfers on a rising edge where in_valid && in_ready && !start.
module boot_loader_next_state
    import boot_loader_pkg::*;
#(
    parameter int          DEPTH    = 256,
    parameter DEFAULT_TYPE HLT_FILL = HLT_FILL_DEFAULT
) (
    input  LOADER_REGS_TYPE i_cur,
    input  logic            i_start,
    input  logic            i_in_valid,
    input  DEFAULT_TYPE     i_in_data,
    input  logic            i_in_last,
    output LOADER_REGS_TYPE o_nxt
);

    localparam logic [8:0] LAST_PTR = 9'(DEPTH - 1);
    localparam logic [8:0] FULL_PTR = 9'(DEPTH);

    logic w_accept;

    assign w_accept = (i_cur.state == LOAD) && i_in_valid && !i_start;

    always_comb begin
        o_nxt           = i_cur;
        o_nxt.rw        = MEMORY_STAY;
        o_nxt.owner     = 1'b1;
        o_nxt.cpu_reset = 1'b1;

        case (i_cur.state)
            IDLE: ;
            LOAD: begin
                if (w_accept) begin
                    o_nxt.rw    = MEMORY_WRITE;
                    o_nxt.addr  = i_cur.ptr[7:0];
                    o_nxt.data  = i_in_data;
                    o_nxt.ptr   = i_cur.ptr + 9'd1;
                    o_nxt.count = i_cur.count + 9'd1;
                    if (i_in_last) begin
                        o_nxt.state = (i_cur.ptr + 9'd1 == FULL_PTR) ? RELEASE : FILL;
                    end else if (i_cur.ptr == LAST_PTR) begin
                        // Memory is full but the stream says more is coming.
                        o_nxt.state = FAULT;
                        o_nxt.error = 1'b1;
                    end
                end
            end
            FILL: begin
                o_nxt.rw   = MEMORY_WRITE;
                o_nxt.addr = i_cur.ptr[7:0];
                o_nxt.data = HLT_FILL;
                o_nxt.ptr  = i_cur.ptr + 9'd1;
                if (i_cur.ptr == LAST_PTR) begin
                    o_nxt.state = RELEASE;
                end
            end
            RELEASE: begin
                // Hand the port to the CPU one cycle before letting it out of reset.
                o_nxt.owner = 1'b0;
                o_nxt.state = RUN;
            end
            RUN: begin
                o_nxt.owner     = 1'b0;
                o_nxt.cpu_reset = 1'b0;
            end
            FAULT: ;
            default: o_nxt.state = IDLE;
        endcase

        if (i_start) begin
            o_nxt.state     = LOAD;
            o_nxt.ptr       = 9'd0;
            o_nxt.count     = 9'd0;
            o_nxt.error     = 1'b0;
            o_nxt.rw        = MEMORY_STAY;
            o_nxt.owner     = 1'b1;
            o_nxt.cpu_reset = 1'b1;
        end

        o_nxt.in_ready = (o_nxt.state == LOAD);
    end

endmodule

// File: rtl/boot_loader.sv
// Program loader: streams bytes into memory, pads with HLT, then releases the CPU.
// Handshake: a byte transfers on a rising edge where in_valid && in_ready && !start.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int          DEPTH    = 256,
    parameter DEFAULT_TYPE HLT_FILL = HLT_FILL_DEFAULT
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             start,
    input  logic             in_valid,
    input  DEFAULT_TYPE      in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       mem_address,
    output DEFAULT_TYPE      mem_write_value,
    output MEMORY_FLAG_TYPE  mem_rw_flag,
    output logic             mem_owner,
    output logic             cpu_reset,
    output logic [8:0]       loaded_count,
    output logic             error,
    output LOADER_STATE_TYPE dbg_state
);

    LOADER_REGS_TYPE r_regs;
    LOADER_REGS_TYPE w_nxt;

    boot_loader_next_state #(
        .DEPTH    (DEPTH),
        .HLT_FILL (HLT_FILL)
    ) u_next_state (
        .i_cur      (r_regs),
        .i_start    (start),
        .i_in_valid (in_valid),
        .i_in_data  (in_data),
        .i_in_last  (in_last),
        .o_nxt      (w_nxt)
    );

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_regs <= LOADER_RESET;
        end else begin
            r_regs <= w_nxt;
        end
    end

    assign in_ready        = r_regs.in_ready;
    assign mem_address     = r_regs.addr;
    assign mem_write_value = r_regs.data;
    assign mem_rw_flag     = r_regs.rw;
    assign mem_owner       = r_regs.owner;
    assign cpu_reset       = r_regs.cpu_reset;
    assign loaded_count    = r_regs.count;
    assign error           = r_regs.error;
    assign dbg_state       = r_regs.state;

endmodule
